// File: rtl/adc_lane_align.sv
// adc_lane_align
// Training-time bitslip alignment controller for a two-lane LVDS ADC receive
// path. During training it slips each lane until the deserialized word matches
// TRAIN_PATTERN for MATCH_COUNT consecutive valid samples. It then reports
// aligned. If a lane runs out of slips, it reports error instead.
module adc_lane_align #(
    parameter int unsigned       DATA_W        = 8,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'hF0,
    parameter int unsigned       SETTLE_CYCLES = 4,
    parameter int unsigned       MATCH_COUNT   = 16,
    parameter int unsigned       MAX_SLIPS     = 2 * DATA_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           word_valid,
    input  logic [DATA_W-1:0]              ln0_word,
    input  logic [DATA_W-1:0]              ln1_word,
    output logic                           bitslip0,
    output logic                           bitslip1,
    output logic                           busy,
    output logic                           aligned,
    output logic                           error,
    output logic [$clog2(MAX_SLIPS+1)-1:0] slip_cnt0,
    output logic [$clog2(MAX_SLIPS+1)-1:0] slip_cnt1
);

    localparam int unsigned SW = $clog2(MAX_SLIPS + 1);
    localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
    localparam int unsigned TW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     settle_q, settle_d;
    logic [MW-1:0]     match_q [2];
    logic [MW-1:0]     match_d [2];
    logic [SW-1:0]     slip_q [2];
    logic [SW-1:0]     slip_d [2];
    logic [1:0]        locked_q, locked_d;
    logic [1:0]        pulse_q, pulse_d;
    logic [DATA_W-1:0] word_w [2];
    logic              any_fail;
    logic              any_slip;

    assign word_w[0] = ln0_word;
    assign word_w[1] = ln1_word;

    // State, per-lane counters and registered bitslip pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            settle_q   <= '0;
            match_q[0] <= '0;
            match_q[1] <= '0;
            slip_q[0]  <= '0;
            slip_q[1]  <= '0;
            locked_q   <= '0;
            pulse_q    <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            match_q[0] <= match_d[0];
            match_q[1] <= match_d[1];
            slip_q[0]  <= slip_d[0];
            slip_q[1]  <= slip_d[1];
            locked_q   <= locked_d;
            pulse_q    <= pulse_d;
        end
    end

    // Next-state: settle countdown, per-lane compare/slip, and CHECK resolution
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        match_d[0] = match_q[0];
        match_d[1] = match_q[1];
        slip_d[0]  = slip_q[0];
        slip_d[1]  = slip_q[1];
        locked_d   = locked_q;
        pulse_d    = '0;
        any_fail   = 1'b0;
        any_slip   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d    = S_SETTLE;
                    settle_d   = TW'(SETTLE_CYCLES);
                    match_d[0] = '0;
                    match_d[1] = '0;
                    slip_d[0]  = '0;
                    slip_d[1]  = '0;
                    locked_d   = '0;
                end
            end
            S_SETTLE: begin
                if (settle_q <= TW'(1)) begin
                    settle_d = '0;
                    state_d  = S_CHECK;
                end else begin
                    settle_d = settle_q - TW'(1);
                end
            end
            S_CHECK: begin
                if (word_valid) begin
                    for (int unsigned i = 0; i < 2; i++) begin
                        if (!locked_q[i]) begin
                            if (word_w[i] == TRAIN_PATTERN) begin
                                match_d[i] = match_q[i] + MW'(1);
                                if (match_q[i] == MW'(MATCH_COUNT - 1)) begin
                                    locked_d[i] = 1'b1;
                                end
                            end else begin
                                match_d[i] = '0;
                                if (slip_q[i] < SW'(MAX_SLIPS)) begin
                                    slip_d[i]  = slip_q[i] + SW'(1);
                                    pulse_d[i] = 1'b1;
                                    any_slip   = 1'b1;
                                end else begin
                                    any_fail = 1'b1;
                                end
                            end
                        end
                    end
                    // Lock test uses locked_d so a lane locking this cycle counts.
                    if (any_fail) begin
                        state_d = S_FAIL;
                    end else if (any_slip) begin
                        state_d  = S_SETTLE;
                        settle_d = TW'(SETTLE_CYCLES);
                    end else if (&locked_d) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bitslip0  = pulse_q[0];
    assign bitslip1  = pulse_q[1];
    assign busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign aligned   = (state_q == S_DONE);
    assign error     = (state_q == S_FAIL);
    assign slip_cnt0 = slip_q[0];
    assign slip_cnt1 = slip_q[1];

endmodule

// File: tb/tb_adc_lane_align.sv
// Testbench for adc_lane_align.
// Two rotating-deserializer lane models drive the DUT. A deadline-based
// reference model predicts every output on every cycle.
module tb_adc_lane_align;

    localparam int unsigned DW     = 8;
    localparam logic [7:0]  PAT    = 8'hF0;
    localparam int          SETTLE = 4;
    localparam int          MATCH  = 16;
    localparam int          MAXS   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       word_valid;
    logic [7:0] ln0_word;
    logic [7:0] ln1_word;
    logic       bitslip0;
    logic       bitslip1;
    logic       busy;
    logic       aligned;
    logic       error;
    logic [4:0] slip_cnt0;
    logic [4:0] slip_cnt1;

    always #5 clk = ~clk;

    adc_lane_align #(
        .DATA_W        (DW),
        .TRAIN_PATTERN (PAT),
        .SETTLE_CYCLES (SETTLE),
        .MATCH_COUNT   (MATCH),
        .MAX_SLIPS     (MAXS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_valid (word_valid),
        .ln0_word   (ln0_word),
        .ln1_word   (ln1_word),
        .bitslip0   (bitslip0),
        .bitslip1   (bitslip1),
        .busy       (busy),
        .aligned    (aligned),
        .error      (error),
        .slip_cnt0  (slip_cnt0),
        .slip_cnt1  (slip_cnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Lane environment: misalignment in bits, each slip removes one bit.
    int m0, m1;
    bit stuck0, stuck1, inj0;

    // Reference model state
    bit       e_busy, e_aligned, e_error;
    bit [1:0] e_pulse;
    bit [1:0] e_lock;
    int       e_mc [2];
    int       e_slips [2];
    int       resume_at;
    int       cyc;

    // Per-run observation
    int rel, p0, p1, pboth, last0, last1, gap0, gap1, done_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int m);
        logic [15:0] t;
        t = {x, x} << m;
        return t[15:8];
    endfunction

    task automatic drive_lanes();
        ln0_word = stuck0 ? 8'h00 : (inj0 ? 8'h0F : rotl(PAT, m0));
        ln1_word = stuck1 ? 8'h00 : rotl(PAT, m1);
    endtask

    task automatic model_reset();
        e_busy = 0; e_aligned = 0; e_error = 0; e_pulse = '0; e_lock = '0;
        e_mc[0] = 0; e_mc[1] = 0; e_slips[0] = 0; e_slips[1] = 0;
    endtask

    // One sampling edge of the reference. Comparing resumes at an absolute cycle deadline.
    task automatic model_step();
        bit fail, slip;
        logic [7:0] w [2];
        w[0] = ln0_word;
        w[1] = ln1_word;
        e_pulse = '0;
        if (!e_busy) begin
            if (start) begin
                e_busy = 1; e_aligned = 0; e_error = 0; e_lock = '0;
                e_mc[0] = 0; e_mc[1] = 0; e_slips[0] = 0; e_slips[1] = 0;
                resume_at = cyc + 1 + SETTLE;
            end
        end else if (cyc >= resume_at && word_valid) begin
            fail = 0;
            slip = 0;
            for (int i = 0; i < 2; i++) begin
                if (!e_lock[i]) begin
                    if (w[i] == PAT) begin
                        e_mc[i]++;
                        if (e_mc[i] == MATCH) e_lock[i] = 1;
                    end else begin
                        e_mc[i] = 0;
                        if (e_slips[i] < MAXS) begin
                            e_slips[i]++;
                            e_pulse[i] = 1;
                            slip = 1;
                        end else begin
                            fail = 1;
                        end
                    end
                end
            end
            if (fail) begin
                e_busy = 0; e_error = 1;
            end else if (slip) begin
                resume_at = cyc + 1 + SETTLE;
            end else if (&e_lock) begin
                e_busy = 0; e_aligned = 1;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        logic s0, s1;
        s0 = bitslip0;
        s1 = bitslip1;
        model_step();
        @(posedge clk);
        #1;
        if (s0 === 1'b1) m0 = (m0 + 7) % 8;
        if (s1 === 1'b1) m1 = (m1 + 7) % 8;
        rel++;
        if (bitslip0 === 1'b1) begin
            p0++;
            if (rel - last0 < gap0) gap0 = rel - last0;
            last0 = rel;
        end
        if (bitslip1 === 1'b1) begin
            p1++;
            if (rel - last1 < gap1) gap1 = rel - last1;
            last1 = rel;
        end
        if (bitslip0 === 1'b1 && bitslip1 === 1'b1) pboth++;
        chk("bitslip0",  32'(bitslip0),  32'(e_pulse[0]));
        chk("bitslip1",  32'(bitslip1),  32'(e_pulse[1]));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("aligned",   32'(aligned),   32'(e_aligned));
        chk("error",     32'(error),     32'(e_error));
        chk("slip_cnt0", 32'(slip_cnt0), 32'(e_slips[0]));
        chk("slip_cnt1", 32'(slip_cnt1), 32'(e_slips[1]));
    endtask

    task automatic begin_run(input int r0, input int r1, input bit st0, input bit st1);
        m0 = r0; m1 = r1; stuck0 = st0; stuck1 = st1; inj0 = 0;
        rel = 0; p0 = 0; p1 = 0; pboth = 0;
        last0 = -1000; last1 = -1000; gap0 = 1000; gap1 = 1000; done_at = -1;
        word_valid = 1;
        start = 1;
        drive_lanes();
        tick();
        start = 0;
        chk("start_status_clear", 32'({aligned, error}), 32'd0);
    endtask

    task automatic run_scenario(input int r0, input int r1, input bit st0, input bit st1,
                                input int vpct, input int inj_at, input int stray_at,
                                input bit rnd_stray);
        begin_run(r0, r1, st0, st1);
        for (int k = 0; k < 3000 && (e_busy || busy === 1'b1); k++) begin
            word_valid = ($urandom_range(99) < vpct);
            inj0  = (rel == inj_at);
            start = (rel == stray_at) || (rnd_stray && e_busy && $urandom_range(39) == 0);
            drive_lanes();
            tick();
            if (done_at < 0 && (aligned === 1'b1 || error === 1'b1)) done_at = rel;
        end
        start = 0;
        inj0  = 0;
        chk("run_end_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bitslip0"}, 32'(bitslip0), 32'd0);
        chk({tag, "_bitslip1"}, 32'(bitslip1), 32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_aligned"},  32'(aligned),  32'd0);
        chk({tag, "_error"},    32'(error),    32'd0);
        chk({tag, "_slip0"},    32'(slip_cnt0), 32'd0);
        chk({tag, "_slip1"},    32'(slip_cnt1), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired: observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim;
        rst_n = 0; start = 0; word_valid = 0;
        m0 = 0; m1 = 0; stuck0 = 0; stuck1 = 0; inj0 = 0;
        cyc = 0; resume_at = 0;
        drive_lanes();
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1;

        // 1: both lanes aligned, continuous valid
        run_scenario(0, 0, 0, 0, 100, -1, -1, 0);
        chk("t1_aligned_at", 32'(done_at), 32'd21);
        chk("t1_aligned", 32'(aligned), 32'd1);
        chk("t1_pulses", 32'(p0 + p1), 32'd0);

        // 2: lane 1 rotated by 3
        run_scenario(0, 3, 0, 0, 100, -1, -1, 0);
        chk("t2_p1", 32'(p1), 32'd3);
        chk("t2_p0", 32'(p0), 32'd0);
        chk("t2_gap_ok", 32'(gap1 >= 5), 32'd1);
        chk("t2_slip1", 32'(slip_cnt1), 32'd3);
        chk("t2_aligned", 32'(aligned), 32'd1);

        // 3: lane 0 stuck at 0x00
        run_scenario(0, 0, 1, 0, 100, -1, -1, 0);
        chk("t3_p0", 32'(p0), 32'd16);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_aligned", 32'(aligned), 32'd0);
        chk("t3_slip0", 32'(slip_cnt0), 32'd16);

        // 4: both lanes misaligned
        run_scenario(2, 5, 0, 0, 100, -1, -1, 0);
        chk("t4_both", 32'(pboth), 32'd2);
        chk("t4_slip0", 32'(slip_cnt0), 32'd2);
        chk("t4_slip1", 32'(slip_cnt1), 32'd5);
        chk("t4_aligned", 32'(aligned), 32'd1);

        // 5: one injected mismatch after ten matches on lane 0
        run_scenario(0, 0, 0, 0, 100, 15, -1, 0);
        chk("t5_slip0", 32'(slip_cnt0), 32'd8);
        chk("t5_aligned", 32'(aligned), 32'd1);

        // 6a: stray start mid-CHECK has no effect
        run_scenario(0, 0, 0, 0, 100, -1, 8, 0);
        chk("t6_stray_aligned_at", 32'(done_at), 32'd21);

        // 6b: restart from DONE, then reset while a bitslip pulse is high
        begin_run(0, 3, 0, 0);
        chk("t6_restart_aligned", 32'(aligned), 32'd0);
        lim = 0;
        while (bitslip1 !== 1'b1 && lim < 60) begin
            tick();
            lim++;
        end
        chk("t6_pulse_seen", 32'(bitslip1), 32'd1);
        rst_n = 0;
        #1;
        model_reset();
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        check_all_zero("rsthold");
        rst_n = 1;

        // 6c: training reruns after reset
        run_scenario(1, 4, 0, 0, 100, -1, -1, 0);
        chk("t6_rerun_aligned", 32'(aligned), 32'd1);

        // Randomized runs: random rotations, sparse valid, stray starts, injections
        for (int n = 0; n < 14; n++) begin
            run_scenario($urandom_range(7), $urandom_range(7),
                         $urandom_range(9) == 0, $urandom_range(11) == 0,
                         $urandom_range(100, 30),
                         ($urandom_range(2) == 0) ? $urandom_range(60, 6) : -1,
                         -1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
